// File: rtl/axi_sync_filter.sv
// axi_sync_filter: multi-channel level synchroniser with optional stability filter.
// Each channel passes an asynchronous level through a STAGES-deep flop chain, then
// through a filter that only accepts a new level after FILTER_CYCLES consecutive
// cycles of disagreement. Registered rise/fall pulses mark each accepted edge.
module axi_sync_filter #(
    parameter int unsigned       WIDTH         = 1,
    parameter int unsigned       STAGES        = 2,
    parameter logic [WIDTH-1:0]  RESET_VALUE   = '0,
    parameter int unsigned       FILTER_CYCLES = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] serial_i,
    output logic [WIDTH-1:0] serial_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             change_o
);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
        (* async_reg = "true", dont_touch = "true" *)
        logic [STAGES-1:0] stage_q;

        // Plain shift chain: no logic between synchroniser stages.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stage_q <= {STAGES{RESET_VALUE[ch]}};
            end else begin
                stage_q <= {stage_q[STAGES-2:0], serial_i[ch]};
            end
        end

        assign sync[ch] = stage_q[STAGES-1];

        if (FILTER_CYCLES == 0) begin : g_bypass
            assign state_d[ch] = sync[ch];
        end else begin : g_filter
            localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);
            localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);

            logic [CntW-1:0] cnt_q;
            logic [CntW-1:0] cnt_d;
            logic            state_nxt;

            // Count consecutive disagreement; accept the new level on the last count.
            always_comb begin
                cnt_d     = '0;
                state_nxt = state_q[ch];
                if (sync[ch] != state_q[ch]) begin
                    if (cnt_q == CntLast) begin
                        state_nxt = sync[ch];
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            // Disagreement counter; any agreement or reset discards a partial count.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign state_d[ch] = state_nxt;
        end
    end

    // Filtered level plus edge pulses, all aligned to the cycle the level updates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            state_q <= state_d;
            rise_q  <= state_d & ~state_q;
            fall_q  <= ~state_d & state_q;
        end
    end

    assign serial_o = state_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign change_o = |(rise_q | fall_q);

endmodule

// File: tb/tb_axi_sync_filter.sv
// Bench for axi_sync_filter: a filtered 4-channel instance checked every cycle against
// a history-window model, plus an unfiltered 1-channel instance checked by pure delay.
module tb_axi_sync_filter;

    localparam int unsigned W  = 4;
    localparam int unsigned S  = 3;
    localparam int unsigned F  = 4;
    localparam logic [W-1:0] RV = 4'b1010;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] si  = RV;
    logic [W-1:0] so, ro, fo;
    logic         co;
    logic         s0_i = 1'b0;
    logic         s0_o, r0_o, f0_o, c0_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_sync_filter #(
        .WIDTH(W), .STAGES(S), .RESET_VALUE(RV), .FILTER_CYCLES(F)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .serial_i(si),
        .serial_o(so), .rise_o(ro), .fall_o(fo), .change_o(co)
    );

    axi_sync_filter #(
        .WIDTH(1), .STAGES(2), .RESET_VALUE(1'b0), .FILTER_CYCLES(0)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .serial_i(s0_i),
        .serial_o(s0_o), .rise_o(r0_o), .fall_o(f0_o), .change_o(c0_o)
    );

    // Model state. hist[0] is the newest sample of serial_i; the filter sees sample
    // n-S at edge n, and accepts when the last F seen values all differ from state.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_state, m_rise, m_fall;
    logic         h0[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < int'(S + F + 1); i++) hist.push_back(RV);
        m_state = RV;
        m_rise  = '0;
        m_fall  = '0;
        h0.delete();
        for (int i = 0; i < 4; i++) h0.push_back(1'b0);
    endtask

    task automatic model_step(input logic [W-1:0] x, input logic x0);
        logic [W-1:0] nxt;
        logic [W-1:0] v;
        logic         all_diff;
        hist.push_front(x);
        while (hist.size() > int'(S + F + 1)) void'(hist.pop_back());
        nxt = m_state;
        for (int b = 0; b < int'(W); b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < int'(F); k++) begin
                v = hist[S + k];
                if (v[b] == m_state[b]) all_diff = 1'b0;
            end
            if (all_diff) nxt[b] = ~m_state[b];
        end
        m_rise  = nxt & ~m_state;
        m_fall  = ~nxt & m_state;
        m_state = nxt;
        h0.push_front(x0);
        while (h0.size() > 4) void'(h0.pop_back());
    endtask

    task automatic compare_all();
        check("serial_o", 32'(so), 32'(m_state));
        check("rise_o", 32'(ro), 32'(m_rise));
        check("fall_o", 32'(fo), 32'(m_fall));
        check("change_o", 32'(co), 32'(|(m_rise | m_fall)));
        check("rise_and_fall", 32'(ro & fo), 32'd0);
        check("dut0_serial_o", 32'(s0_o), 32'(h0[2]));
        check("dut0_rise_o", 32'(r0_o), 32'(h0[2] & ~h0[3]));
        check("dut0_fall_o", 32'(f0_o), 32'(~h0[2] & h0[3]));
    endtask

    // One clock: advance the model at the edge, compare at the following falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_step(si, s0_i);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        repeat (3) step();
        check("reset_serial_o", 32'(so), 32'h a);
        check("reset_pulses", 32'({ro, fo, co}), 32'd0);
        check("reset_dut0", 32'(s0_o), 32'd0);

        // Release with input equal to reset level; dut0 sees a 0->1 before edge 1.
        rst  = 1'b0;
        s0_i = 1'b1;
        step();
        check("d0_edge1", 32'(s0_o), 32'd0);
        step();
        check("d0_edge2", 32'(s0_o), 32'd0);
        step();
        check("d0_edge3_level", 32'(s0_o), 32'd1);
        check("d0_edge3_rise", 32'(r0_o), 32'd1);
        check("model_d0_edge3", 32'(h0[2]), 32'd1);
        step();
        check("d0_edge4_rise", 32'(r0_o), 32'd0);
        repeat (16) begin
            step();
            check("idle_no_pulse", 32'({ro, fo}), 32'd0);
        end

        // Three-cycle glitch on channel 0 must be discarded.
        si = 4'b1011;
        repeat (3) step();
        si = 4'b1010;
        repeat (8) step();
        check("glitch_level", 32'(so), 32'h a);
        check("model_glitch", 32'(m_state), 32'h a);

        // Held change: visible exactly S+F = 7 edges after first sample.
        si = 4'b1011;
        repeat (6) step();
        check("hold_edge6", 32'(so), 32'h a);
        step();
        check("hold_edge7", 32'(so), 32'h b);
        check("hold_rise", 32'(ro), 32'h 1);
        check("model_hold_edge7", 32'(m_state), 32'h b);
        step();
        check("hold_rise_gone", 32'(ro), 32'h 0);

        // Reset between edges while a fall on channel 3 is part-way through its window.
        si = 4'b0011;
        repeat (5) step();
        #2 rst = 1'b1;
        #1 model_reset();
        check("async_rst_level", 32'(so), 32'h a);
        check("async_rst_pulses", 32'({ro, fo, co}), 32'd0);
        step();
        step();
        rst = 1'b0;
        repeat (6) step();
        check("rearm_edge6", 32'(so), 32'h a);
        step();
        check("rearm_edge7", 32'(so), 32'h 3);
        check("rearm_rise", 32'(ro), 32'h 1);
        check("rearm_fall", 32'(fo), 32'h 8);

        // Random phase: sparse bit flips so some survive the filter, rare async resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int b = 0; b < int'(W); b++) begin
                if ($urandom_range(7) == 0) si[b] = ~si[b];
            end
            if ($urandom_range(3) == 0) s0_i = ~s0_i;
            if ($urandom_range(250) == 0) begin
                #($urandom_range(1, 3)) rst = 1'b1;
                #1 model_reset();
                check("rand_async_rst", 32'(so), 32'(RV));
                repeat ($urandom_range(1, 2)) step();
                rst = 1'b0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
